// File: rtl/end_around_receiver.sv
// Serial-to-parallel receiver for a rotating (end-around) shift register, LSB first.
// An optional second revolution is compared against the first to flag a corrupted ring.
module end_around_receiver #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             verify,
    input  logic             sin,
    output logic [WIDTH-1:0] Q,
    output logic             valid,
    output logic             err,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        CHECK
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic             r_verify;
    logic             r_mis;
    logic             r_valid;
    logic             r_err;
    logic             w_lastBit;
    logic             w_m;

    assign w_lastBit = (r_cnt == CW'(WIDTH - 1));
    assign w_m       = sin ^ r_sreg[r_cnt];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = CAPTURE;
                end
            end
            CAPTURE: begin
                if (w_lastBit) begin
                    w_nextState = r_verify ? CHECK : IDLE;
                end
            end
            CHECK: begin
                if (w_lastBit) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        busy  = (r_state != IDLE);
        Q     = r_q;
        valid = r_valid;
        err   = r_err;
    end

    // During CHECK, sreg holds the first revolution and each new bit is compared against it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sreg   <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
            r_verify <= 1'b0;
            r_mis    <= 1'b0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sreg[0] <= sin;
                        r_cnt     <= CW'(1);
                        r_verify  <= verify;
                        r_mis     <= 1'b0;
                    end
                end
                CAPTURE: begin
                    r_sreg[r_cnt] <= sin;
                    if (!w_lastBit) begin
                        r_cnt <= r_cnt + CW'(1);
                    end else if (!r_verify) begin
                        r_cnt   <= '0;
                        r_q     <= {sin, r_sreg[WIDTH-2:0]};
                        r_err   <= 1'b0;
                        r_valid <= 1'b1;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                CHECK: begin
                    if (!w_lastBit) begin
                        r_mis <= r_mis | w_m;
                        r_cnt <= r_cnt + CW'(1);
                    end else begin
                        r_cnt   <= '0;
                        r_q     <= r_sreg;
                        r_err   <= r_mis | w_m;
                        r_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_end_around_receiver.sv
// Scoreboard bench for end_around_receiver at WIDTH=4 and WIDTH=8, fed from a rotating-ring model.
module tb_end_around_receiver;

    localparam int W  = 4;
    localparam int W8 = 8;

    typedef struct {
        logic [7:0] q;
        logic       e;
        int         cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, verify, sin;
    logic [W-1:0]  Q;
    logic          valid, err, busy;
    logic          start8, verify8, sin8;
    logic [W8-1:0] Q8;
    logic          valid8, err8, busy8;

    exp_t       sb[$];
    exp_t       sb8[$];
    exp_t       e;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    logic       expBusy = 1'b0;
    logic       expBusy8 = 1'b0;
    logic [7:0] holdQ = 8'h0;
    logic [7:0] holdQ8 = 8'h0;
    logic       holdErr = 1'b0;
    logic       holdErr8 = 1'b0;
    logic       ev;
    logic       done = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    end_around_receiver #(.WIDTH(W)) u_dut (
        .clk(clk), .reset(reset), .start(start), .verify(verify), .sin(sin),
        .Q(Q), .valid(valid), .err(err), .busy(busy)
    );

    end_around_receiver #(.WIDTH(W8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .verify(verify8), .sin(sin8),
        .Q(Q8), .valid(valid8), .err(err8), .busy(busy8)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: a frame's expected word is due exactly at the cycle recorded when it started.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            sb8.delete();
            holdQ    = 8'h0;
            holdErr  = 1'b0;
            holdQ8   = 8'h0;
            holdErr8 = 1'b0;
        end else begin
            checkOutput("busy4", busy, expBusy);
            ev = (sb.size() != 0) && (sb[0].cyc == cyc);
            checkOutput("valid4", valid, ev);
            if (ev) begin
                e = sb.pop_front();
                if (valid) begin
                    checkOutput("Q4", Q, e.q);
                    checkOutput("err4", err, e.e);
                end
                holdQ   = e.q;
                holdErr = e.e;
            end else if (!valid) begin
                checkOutput("Q4 hold", Q, holdQ);
                checkOutput("err4 hold", err, holdErr);
            end

            checkOutput("busy8", busy8, expBusy8);
            ev = (sb8.size() != 0) && (sb8[0].cyc == cyc);
            checkOutput("valid8", valid8, ev);
            if (ev) begin
                e = sb8.pop_front();
                if (valid8) begin
                    checkOutput("Q8", Q8, e.q);
                    checkOutput("err8", err8, e.e);
                end
                holdQ8   = e.q;
                holdErr8 = e.e;
            end else if (!valid8) begin
                checkOutput("Q8 hold", Q8, holdQ8);
                checkOutput("err8 hold", err8, holdErr8);
            end
        end
        if (done) begin
            checkOutput("scoreboard drained", sb.size() + sb8.size(), 0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        start    = 1'b0;
        start8   = 1'b0;
        expBusy  = 1'b0;
        expBusy8 = 1'b0;
        repeat (n) begin
            sin     = 1'($urandom);
            sin8    = 1'($urandom);
            verify  = 1'($urandom);
            verify8 = 1'($urandom);
            step();
        end
    endtask

    // The ring is loaded with word and rotated right; corrupt flips bits of the second revolution.
    task automatic applyStimulus(input bit wide, input logic [7:0] word, input logic ver,
                                 input logic [7:0] corrupt, input int abortAt, input bit junk);
        int         n, total;
        logic [7:0] mask, ring, c, second;
        logic       b, s;
        n      = wide ? W8 : W;
        total  = ver ? 2 * n : n;
        mask   = wide ? 8'hFF : 8'h0F;
        ring   = word & mask;
        c      = corrupt & mask;
        second = (word ^ corrupt) & mask;
        for (int k = 0; k < total; k++) begin
            b = ring[0];
            if (k >= n) begin
                b = b ^ c[0];
                c = c >> 1;
            end
            ring = wide ? {ring[0], ring[7:1]} : {4'h0, ring[0], ring[3:1]};
            s = (k == 0) ? 1'b1 : (junk ? 1'($urandom) : 1'b0);
            if (k == abortAt) begin
                reset = 1'b1;
                s     = 1'b1;
            end
            if (wide) begin
                start8   = s;
                sin8     = b;
                verify8  = (k == 0) ? ver : 1'($urandom);
                expBusy8 = (k != 0);
            end else begin
                start   = s;
                sin     = b;
                verify  = (k == 0) ? ver : 1'($urandom);
                expBusy = (k != 0);
            end
            if (k == 0) begin
                if (wide) sb8.push_back('{word & mask, ver && (second != (word & mask)), cyc + total});
                else      sb.push_back('{word & mask, ver && (second != (word & mask)), cyc + total});
            end
            step();
            if (k == abortAt) begin
                reset = 1'b0;
                idle(0);
                return;
            end
        end
        idle(0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        start   = 1'b0; verify  = 1'b0; sin  = 1'b0;
        start8  = 1'b0; verify8 = 1'b0; sin8 = 1'b0;
        step();
        step();
        reset = 1'b0;

        applyStimulus(0, 8'h0B, 1'b0, 8'h00, -1, 0);
        idle(1);
        applyStimulus(0, 8'h0B, 1'b1, 8'h00, -1, 0);
        idle(1);
        applyStimulus(0, 8'h0B, 1'b1, 8'h04, -1, 0);
        idle(1);
        applyStimulus(0, 8'h06, 1'b0, 8'h00, -1, 0);
        idle(1);
        applyStimulus(0, 8'h05, 1'b0, 8'h00, -1, 1);
        applyStimulus(0, 8'h0C, 1'b0, 8'h00, -1, 1);
        idle(2);
        applyStimulus(0, 8'h09, 1'b0, 8'h00, 2, 0);
        applyStimulus(0, 8'h09, 1'b0, 8'h00, -1, 0);
        idle(1);
        applyStimulus(0, 8'h06, 1'b1, 8'h00, -1, 0);
        idle(1);
        applyStimulus(1, 8'hA5, 1'b1, 8'h00, -1, 0);
        idle(1);

        for (int i = 0; i < 150; i++) begin
            logic       v;
            int         tot, ab;
            logic [7:0] w, cr;
            v   = 1'($urandom);
            tot = v ? 2 * W : W;
            w   = 8'($urandom) & 8'h0F;
            cr  = ($urandom_range(0, 2) == 0) ? (8'($urandom) & 8'h0F) : 8'h00;
            ab  = ($urandom_range(0, 12) == 0) ? int'($urandom_range(1, tot - 1)) : -1;
            applyStimulus(0, w, v, cr, ab, 1'($urandom));
            idle(int'($urandom_range(0, 2)));
        end

        for (int i = 0; i < 30; i++) begin
            logic       v;
            int         tot, ab;
            logic [7:0] w, cr;
            v   = 1'($urandom);
            tot = v ? 2 * W8 : W8;
            w   = 8'($urandom);
            cr  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            ab  = ($urandom_range(0, 12) == 0) ? int'($urandom_range(1, tot - 1)) : -1;
            applyStimulus(1, w, v, cr, ab, 1'($urandom));
            idle(int'($urandom_range(0, 2)));
        end

        idle(3);
        done = 1'b1;
    end

endmodule

// File: doc/end_around_receiver.md
# end_around_receiver

Serial-to-parallel receiver for the rotating (end-around) 4-bit shift register: it samples the register's serial output bit, LSB first, and reassembles the parallel word. It can optionally watch a second revolution of the ring and flag any bit that differs from the first, which detects a corrupted ring or a misaligned frame. It sits on the far end of the serial link, next to the rotating register, and drives a parallel word plus a one-cycle `valid` strobe to downstream logic.

## Interface
- `WIDTH`, 4: word length and the ring length in bits; must be ≥ 2. The bit counter is `$clog2(WIDTH)` bits wide.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  frame start; honoured only in IDLE; the cycle it is high carries bit 0 on `sin`.
- `verify`  in  1  sampled together with an accepted `start`; 1 = also check a second revolution.
- `sin`  in  1  serial data, LSB first; one bit per clock.
- `Q`  out  WIDTH  last received word; changes only when `valid` rises.
- `valid`  out  1  one-cycle pulse: `Q`/`err` are updated this cycle.
- `err`  out  1  mismatch flag for the last frame; 0 when that frame had `verify`=0.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- There are three states: IDLE, CAPTURE and CHECK. Internally the block keeps a shift/hold register `sreg`, a bit counter `cnt`, a latched `verify_r` and a mismatch accumulator `mis`.
- **IDLE**, `start`=1:
  - `sreg[0]`<=`sin`, `cnt`<=1, `verify_r`<=`verify`, `mis`<=0.
  - Next state is CAPTURE.
  - When `start`=0 the block stays in IDLE.
- **CAPTURE**, `cnt`=k: `sreg[k]`<=`sin`, then:
  - k < WIDTH-1: `cnt`<=k+1 and stay in CAPTURE.
  - k = WIDTH-1 and `verify_r`=0: go to IDLE, `Q`<={`sin`,`sreg[WIDTH-2:0]`}, `err`<=0, `valid`<=1.
  - k = WIDTH-1 and `verify_r`=1: `cnt`<=0 and go to CHECK.
- **CHECK**, `cnt`=k: compute `m` = `sin` ^ `sreg[k]`.
  - k < WIDTH-1: `mis`<=`mis`|`m`, `cnt`<=k+1.
  - k = WIDTH-1: go to IDLE, `Q`<=`sreg`, `err`<=`mis`|`m`, `valid`<=1.
- `start` while `busy`=1 is ignored: no restart and no error.
- `valid` is registered and deasserts on the following edge unless a new frame completes on that edge.
- Between frames, `Q` and `err` hold their values.
- **Reset:** `Q`=0, `valid`=0, `err`=0, `busy`=0, state IDLE, `cnt`=0, `sreg`=0, `mis`=0.
  - Reset mid-frame aborts the frame: no `valid` pulse.
  - A `start` in the first cycle after reset is accepted.
  - Reset has priority over `start`.

## Timing
- Frame accepted in cycle 0 (`start`=1, `sin`=bit 0); bits 1..WIDTH-1 arrive in cycles 1..WIDTH-1.
- `busy`=1 from cycle 1 through the last capture or check cycle.
- With `verify`=0: `valid`=1 and the new `Q` appear in cycle WIDTH, which is cycle 4 at the default width. Latency is WIDTH cycles from `start`.
- With `verify`=1: the check bits arrive in cycles WIDTH..2·WIDTH-1. `valid` and `err` appear in cycle 2·WIDTH, which is cycle 8 at the default width.
- In the `valid` cycle the state is already IDLE, so a `start` there is accepted. Back-to-back frames carry no gap cycle.
- Bit order matches the rotate-right ring whose output is bit 0: after a parallel load of D, the ring presents D[0], D[1], …, D[WIDTH-1], D[0], … on consecutive cycles.

## Test plan
- **Plain frame:** `start`=1, `verify`=0, `sin`=1,1,0,1 in cycles 0-3 -> cycle 4: `valid`=1, `Q`=4'hB, `err`=0, `busy`=0; cycle 5: `valid`=0, `Q` still 4'hB.
- **Verified frame:** `verify`=1, `sin`=1,1,0,1,1,1,0,1 -> `valid` only in cycle 8, `Q`=4'hB, `err`=0; `busy`=1 in cycles 1-7.
- **Corrupted second revolution:** as the verified frame, but bit 2 of the second revolution is 1 (cycle 6) -> cycle 8: `Q`=4'hB, `err`=1. The next plain frame 4'h6 (`sin`=0,1,1,0) clears `err` to 0.
- **Back-to-back and ignored start:**
  - A plain 4'h5 frame has a new `start` in its `valid` cycle 4 (`sin`=0,0,1,1 in cycles 4-7) -> `valid` in cycle 4 with `Q`=4'h5, and in cycle 8 with `Q`=4'hC.
  - `start` pulses during cycles 1-3 of the first frame cause no restart.
- **Reset mid-frame:** `reset` in cycle 2 of a frame -> cycle 3: `busy`=0, `Q`=0, no `valid` pulse. A following frame 4'h9 completes normally with `Q`=4'h9.
- **Loopback:** parallel-load the rotating register with 4'h6 and assert `start` when its output carries bit 0, with `verify`=1 -> `Q`=4'h6, `err`=0. Repeat with WIDTH=8 and 8'hA5 -> `valid` in cycle 16 with `Q`=8'hA5.
